mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory
// with a one-cycle access stage. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        lat_fetch;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       force_fetch;

    assign force_fetch = if_req && (starve_cnt == LIMIT);

    always_comb begin
        if_gnt = if_req && (force_fetch || !d_req);
        d_gnt  = d_req && !force_fetch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (if_req && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    always_comb begin
        d_gnt  = d_req;
        if_gnt = if_req && !d_req;
    end
`endif

    assign grant = if_gnt || d_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory port is driven only in access cycles; otherwise held at zero.
    always_comb begin
        state_next = IDLE;
        busy       = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (grant) begin
            state_next = ACCESS;
        end
        if (state == ACCESS) begin
            busy      = 1'b1;
            mem_addr  = lat_addr;
            mem_we    = lat_we;
            mem_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_fetch <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            lat_fetch <= if_gnt;
            lat_we    <= d_gnt && d_we;
            lat_addr  <= d_gnt ? d_addr : if_addr;
            lat_wdata <= d_gnt ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (state == ACCESS) begin
                if (lat_fetch) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    d_valid <= 1'b1;
                    if (!lat_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// responses; a negedge monitor pops and checks valid pulses and read data.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    // Single-port memory: combinational read, clocked write, word addressed.
    logic [31:0] tb_mem [0:1023];
    assign mem_rdata = tb_mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[11:2]] <= mem_wdata;
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_if[$];
    exp_t        exp_d[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_if_rdata;
    logic [31:0] ref_d_rdata;
    logic        prev_act;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus with hand-specified grant expectations; memory
    // port outputs are predicted from the previous cycle's expected grant.
    task automatic run_cycle(input logic ifr, input logic [31:0] ifa,
                             input logic dr, input logic dwe,
                             input logic [31:0] da, input logic [31:0] dwd,
                             input logic eig, input logic edg);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        @(negedge clk);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
        chk("busy", {31'd0, busy}, {31'd0, prev_act});
        chk("mem_addr", mem_addr, prev_act ? prev_addr : 32'd0);
        chk("mem_we", {31'd0, mem_we}, {31'd0, prev_act & prev_we});
        if (!prev_act || prev_we)
            chk("mem_wdata", mem_wdata, prev_act ? prev_wdata : 32'd0);
        if (edg) begin
            if (dwe) begin
                ref_mem[da[11:2]] = dwd;
            end else begin
                ref_d_rdata = ref_mem[da[11:2]];
            end
            exp_d.push_back('{ref_d_rdata, cyc + 2});
            prev_act   = 1'b1;
            prev_we    = dwe;
            prev_addr  = da;
            prev_wdata = dwd;
        end else if (eig) begin
            ref_if_rdata = ref_mem[ifa[11:2]];
            exp_if.push_back('{ref_if_rdata, cyc + 2});
            prev_act  = 1'b1;
            prev_we   = 1'b0;
            prev_addr = ifa;
        end else begin
            prev_act = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_if.size() > 0 && exp_if[0].cyc == cyc) begin
            e = exp_if.pop_front();
            chk("if_valid", {31'd0, if_valid}, 32'd1);
            chk("if_rdata", if_rdata, e.data);
        end else begin
            chk("if_valid_idle", {31'd0, if_valid}, 32'd0);
        end
        if (exp_d.size() > 0 && exp_d[0].cyc == cyc) begin
            e = exp_d.pop_front();
            chk("d_valid", {31'd0, d_valid}, 32'd1);
            chk("d_rdata", d_rdata, e.data);
        end else begin
            chk("d_valid_idle", {31'd0, d_valid}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at time %0t, expected earlier", $time);
        $fatal(1);
    end

    initial begin
        logic fetch_win;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 32'd0;
            ref_mem[i] = 32'd0;
        end
        tb_mem[32'h10 >> 2]  = 32'hDEADBEEF;
        ref_mem[32'h10 >> 2] = 32'hDEADBEEF;
        tb_mem[32'h80 >> 2]  = 32'h5555AAAA;
        ref_mem[32'h80 >> 2] = 32'h5555AAAA;
        ref_if_rdata = 32'd0;
        ref_d_rdata  = 32'd0;
        prev_act = 1'b0; prev_we = 1'b0; prev_addr = 32'd0; prev_wdata = 32'd0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fetch, granted in the first cycle after reset release
        run_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(3);

        // Store then load of the same address
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b1);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b1);
        idle(3);
        chk("d_rdata_after_load", d_rdata, 32'h12345678);
        chk("mem_0x40", tb_mem[32'h40 >> 2], 32'h12345678);

        // Contention: both held; guard yields 4 data grants then 1 fetch
        for (int k = 0; k < 12; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            fetch_win = ((k % 5) == 4);
`else
            fetch_win = 1'b0;
`endif
            run_cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'd0, fetch_win, !fetch_win);
        end
        idle(3);

        // Back-to-back alternating grants; each fetch reads the prior store
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'(32'h100 + 4 * i),
                          32'(32'hA0000000 + i), 1'b0, 1'b1);
            else
                run_cycle(1'b1, 32'(32'h100 + 4 * (i - 1)), 1'b0, 1'b0, 32'd0, 32'd0,
                          1'b1, 1'b0);
        end
        idle(3);
        chk("if_rdata_alt", if_rdata, 32'hA0000004);

        // Reset asserted during the access cycle of a store to 0x80
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_store_d_gnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        #1;
        chk("rst_store_mem_we_pre", {31'd0, mem_we}, 32'd1);
        chk("rst_store_mem_addr_pre", mem_addr, 32'h80);
        rst_n = 1'b0;
        #1;
        chk("rst_store_mem_we_async", {31'd0, mem_we}, 32'd0);
        chk("rst_store_busy_async", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("mem_0x80_unchanged", tb_mem[32'h80 >> 2], 32'h5555AAAA);
        chk("rst_if_rdata_cleared", if_rdata, 32'd0);
        chk("rst_d_rdata_cleared", d_rdata, 32'd0);
        rst_n = 1'b1;
        prev_act = 1'b0;
        ref_if_rdata = 32'd0;
        ref_d_rdata  = 32'd0;
        run_cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(4);
        chk("if_rdata_0x80", if_rdata, 32'h5555AAAA);
        chk("if_queue_drained", exp_if.size(), 32'd0);
        chk("d_queue_drained", exp_d.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
